// File: rtl/keypad_calc_pkg.sv
// keypad_calc_pkg -- shared definitions for the keypad calculator.
//   * key index constants for the 16-key active-low keypad
//   * FSM state type (DIV state only exists when KEYPAD_CALC_DIV_EN is defined)
//   * operator type
//   * pow10 helper used to size operands from the DIGITS parameter
package keypad_calc_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;  // add
    localparam logic [3:0] KEY_B    = 4'd11;  // subtract
    localparam logic [3:0] KEY_C    = 4'd12;  // multiply
    localparam logic [3:0] KEY_D    = 4'd13;  // divide (optional)
    localparam logic [3:0] KEY_STAR = 4'd14;  // select operand 1
    localparam logic [3:0] KEY_HASH = 4'd15;  // select operand 2

`ifdef KEYPAD_CALC_DIV_EN
    typedef enum logic [2:0] {
        ST_ENTRY1 = 3'd0,
        ST_ENTRY2 = 3'd1,
        ST_CALC   = 3'd2,
        ST_DIV    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_ENTRY1 = 3'd0,
        ST_ENTRY2 = 3'd1,
        ST_CALC   = 3'd2,
        ST_DONE   = 3'd4
    } state_e;
`endif

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/keypad_calc_div.sv
// keypad_calc_div -- W-cycle restoring unsigned divider.
// Ports:
//   clk, rst          clock, synchronous active-high reset (control only)
//   start             1-cycle pulse: load dividend/divisor, begin iterating
//   dividend, divisor W-bit unsigned operands (divisor assumed non-zero)
//   done              high during the last of the W iteration cycles
//   quotient          final quotient, valid whenever done is high
// Only instantiated when KEYPAD_CALC_DIV_EN is defined.
module keypad_calc_div #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CW = $clog2(W + 1);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;

    logic [W:0]    shifted;
    logic          ge;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  quo_nx;

    always_comb begin
        // One restoring step: bring in the next dividend bit, subtract if it fits.
        // The trial remainder is always < 2*divisor, so after a successful
        // subtraction the low W bits hold the exact new remainder.
        shifted  = {rem_q, quo_q[W-1]};
        ge       = (shifted >= {1'b0, divisor});
        rem_nx   = ge ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
        quo_nx   = {quo_q[W-2:0], ge};
        done     = run_q && (cnt_q == CW'(W - 1));
        quotient = quo_nx;

        run_d = run_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            rem_d = '0;
            quo_d = dividend;
        end else if (run_q) begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + CW'(1);
            if (done) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
    end

endmodule

// File: rtl/keypad_calc.sv
// keypad_calc -- two-operand decimal keypad calculator.
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   keys_n     16 active-low keys: 0-9 digits, 10 A add, 11 B sub, 12 C mul,
//              13 D div, 14 * select operand 1, 15 # select operand 2
//   resultado  magnitude of last result (2W bits)
//   sinal      1 = result negative
//   valid      resultado/sinal hold a fresh result
//   busy       calculation in progress, keys ignored
//   erro       division by zero flagged
// Build option: define KEYPAD_CALC_DIV_EN to enable the D key and the
// sequential divider; otherwise D is ignored and erro is tied low.
module keypad_calc
    import keypad_calc_pkg::*;
#(
    parameter  int DIGITS = 2,
    localparam int W      = $clog2(pow10(DIGITS))
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    keys_n,
    output logic [2*W-1:0] resultado,
    output logic           sinal,
    output logic           valid,
    output logic           busy,
    output logic           erro
);

    localparam int PMOD = pow10(DIGITS - 1);

    state_e         state_q, state_d;
    logic [15:0]    keys_q, keys_d;      // registered keys, active-high
    logic [15:0]    prev_q, prev_d;      // previous registered keys
    logic [W-1:0]   op1_q, op1_d;
    logic [W-1:0]   op2_q, op2_d;
    op_e            opr_q, opr_d;
    logic [2*W-1:0] res_q, res_d;
    logic           sinal_q, sinal_d;
    logic           valid_q, valid_d;

    logic [15:0]    key_rise;
    logic           key_hit;
    logic [3:0]     key_idx;
    logic [2*W-1:0] a_ext, b_ext;

    // Shift a decimal digit in from the right, dropping the leading digit.
    function automatic logic [W-1:0] digit_shift(input logic [W-1:0] op,
                                                 input logic [3:0]   d);
        logic [W-1:0] m;
        m = op % W'(PMOD);
        return m * W'(10) + W'(d);
    endfunction

`ifdef KEYPAD_CALC_DIV_EN
    logic         erro_q, erro_d;
    logic         div_start;
    logic         div_done;
    logic [W-1:0] div_quo;

    keypad_calc_div #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (op1_q),
        .divisor  (op2_q),
        .done     (div_done),
        .quotient (div_quo)
    );
`endif

    always_comb begin
        keys_d   = ~keys_n;
        prev_d   = keys_q;
        key_rise = keys_q & ~prev_q;

        // Lowest newly pressed key wins; the rest are lost until re-pressed.
        key_hit = 1'b0;
        key_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (key_rise[i]) begin
                key_hit = 1'b1;
                key_idx = 4'(i);
            end
        end

        a_ext = {{W{1'b0}}, op1_q};
        b_ext = {{W{1'b0}}, op2_q};

        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        opr_d   = opr_q;
        res_d   = res_q;
        sinal_d = sinal_q;
        valid_d = valid_q;
`ifdef KEYPAD_CALC_DIV_EN
        erro_d    = erro_q;
        div_start = 1'b0;
`endif

        case (state_q)
            ST_ENTRY1, ST_ENTRY2, ST_DONE: begin
                if (key_hit) begin
                    if (key_idx <= 4'd9) begin
                        if (state_q == ST_ENTRY1)      op1_d = digit_shift(op1_q, key_idx);
                        else if (state_q == ST_ENTRY2) op2_d = digit_shift(op2_q, key_idx);
                    end else if (key_idx == KEY_STAR) begin
                        if (state_q != ST_ENTRY1) begin
                            state_d = ST_ENTRY1;
                            valid_d = 1'b0;
                        end
                    end else if (key_idx == KEY_HASH) begin
                        if (state_q != ST_ENTRY2) begin
                            state_d = ST_ENTRY2;
                            valid_d = 1'b0;
                        end
                    end else if (key_idx == KEY_A || key_idx == KEY_B || key_idx == KEY_C) begin
                        opr_d   = (key_idx == KEY_A) ? OP_ADD :
                                  (key_idx == KEY_B) ? OP_SUB : OP_MUL;
                        state_d = ST_CALC;
                        valid_d = 1'b0;
`ifdef KEYPAD_CALC_DIV_EN
                        erro_d  = 1'b0;
                    end else if (key_idx == KEY_D) begin
                        opr_d = OP_DIV;
                        if (op2_q == '0) begin
                            state_d = ST_DONE;
                            res_d   = '0;
                            sinal_d = 1'b0;
                            valid_d = 1'b1;
                            erro_d  = 1'b1;
                        end else begin
                            state_d   = ST_DIV;
                            valid_d   = 1'b0;
                            erro_d    = 1'b0;
                            div_start = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_CALC: begin
                case (opr_q)
                    OP_SUB: begin
                        if (op1_q >= op2_q) begin
                            res_d   = a_ext - b_ext;
                            sinal_d = 1'b0;
                        end else begin
                            res_d   = b_ext - a_ext;
                            sinal_d = 1'b1;
                        end
                    end
                    OP_MUL: begin
                        res_d   = a_ext * b_ext;
                        sinal_d = 1'b0;
                    end
                    default: begin
                        res_d   = a_ext + b_ext;
                        sinal_d = 1'b0;
                    end
                endcase
                valid_d = 1'b1;
                state_d = ST_DONE;
            end
`ifdef KEYPAD_CALC_DIV_EN
            ST_DIV: begin
                if (div_done) begin
                    res_d   = {{W{1'b0}}, div_quo};
                    sinal_d = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_ENTRY1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ENTRY1;
            keys_q  <= '0;
            prev_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            opr_q   <= OP_ADD;
            res_q   <= '0;
            sinal_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef KEYPAD_CALC_DIV_EN
            erro_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            prev_q  <= prev_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opr_q   <= opr_d;
            res_q   <= res_d;
            sinal_q <= sinal_d;
            valid_q <= valid_d;
`ifdef KEYPAD_CALC_DIV_EN
            erro_q  <= erro_d;
`endif
        end
    end

    assign resultado = res_q;
    assign sinal     = sinal_q;
    assign valid     = valid_q;
`ifdef KEYPAD_CALC_DIV_EN
    assign busy      = (state_q == ST_CALC) || (state_q == ST_DIV);
    assign erro      = erro_q;
`else
    assign busy      = (state_q == ST_CALC);
    assign erro      = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_calc.sv
// tb_keypad_calc -- directed bench for keypad_calc with DIGITS=2 (W=7).
module tb_keypad_calc;
    import keypad_calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys_n = 16'hFFFF;
    logic [13:0] resultado;
    logic        sinal, valid, busy, erro;

    int errors = 0;
    int checks = 0;
    int cnt;

    keypad_calc #(.DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .keys_n    (keys_n),
        .resultado (resultado),
        .sinal     (sinal),
        .valid     (valid),
        .busy      (busy),
        .erro      (erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Press and release a key; returns at the falling edge right after the
    // clock edge on which the FSM acts on the key.
    task automatic press(input int k);
        @(negedge clk);
        keys_n[k] = 1'b0;
        @(negedge clk);
        keys_n = 16'hFFFF;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_res"},   32'(resultado), 32'd0);
        chk({tag, "_sinal"}, 32'(sinal), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_erro"},  32'(erro), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(ST_ENTRY1));
        chk({tag, "_op1"},   32'(dut.op1_q), 32'd0);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        rst = 1'b0;

        // 12 + 34
        press(14); press(1); press(2); press(15); press(3); press(4);
        chk("op1_12", 32'(dut.op1_q), 32'd12);
        chk("op2_34", 32'(dut.op2_q), 32'd34);
        press(10);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_valid_early", 32'(valid), 32'd0);
        @(negedge clk);
        chk("add_res", 32'(resultado), 32'd46);
        chk("add_sinal", 32'(sinal), 32'd0);
        chk("add_valid", 32'(valid), 32'd1);
        chk("add_busy_off", 32'(busy), 32'd0);

        // 12 - 34 negative
        press(11); @(negedge clk);
        chk("sub_neg_res", 32'(resultado), 32'd22);
        chk("sub_neg_sinal", 32'(sinal), 32'd1);
        chk("sub_neg_valid", 32'(valid), 32'd1);

        // *,4,5,B : 45 - 34
        press(14);
        chk("star_clr_valid", 32'(valid), 32'd0);
        press(4); press(5);
        chk("op1_45", 32'(dut.op1_q), 32'd45);
        press(11); @(negedge clk);
        chk("sub_pos_res", 32'(resultado), 32'd11);
        chk("sub_pos_sinal", 32'(sinal), 32'd0);

        // *,1,2,3 -> 23 ; #,9,9 -> 99 ; C
        press(14); press(1); press(2); press(3);
        chk("op1_23", 32'(dut.op1_q), 32'd23);
        press(15); press(9); press(9);
        chk("op2_99", 32'(dut.op2_q), 32'd99);
        press(12); @(negedge clk);
        chk("mul_res", 32'(resultado), 32'd2277);
        chk("mul_sinal", 32'(sinal), 32'd0);

        // Digit in DONE ignored
        press(7);
        chk("done_digit_valid", 32'(valid), 32'd1);
        chk("done_digit_res", 32'(resultado), 32'd2277);
        chk("done_digit_op2", 32'(dut.op2_q), 32'd99);
        chk("done_digit_state", 32'(dut.state_q), 32'(ST_DONE));

        // Held key acts once
        do_reset();
        @(negedge clk);
        keys_n[5] = 1'b0;
        repeat (10) @(negedge clk);
        keys_n = 16'hFFFF;
        repeat (2) @(negedge clk);
        chk("held_op1", 32'(dut.op1_q), 32'd5);

        // Simultaneous keys: lowest index
        do_reset();
        @(negedge clk);
        keys_n[3] = 1'b0;
        keys_n[7] = 1'b0;
        @(negedge clk);
        keys_n = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("simul_op1", 32'(dut.op1_q), 32'd3);

`ifdef KEYPAD_CALC_DIV_EN
        // 99 / 7, with a key press injected while busy
        do_reset();
        press(9); press(9); press(15); press(7);
        press(13);
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            if (cnt == 1) keys_n[15] = 1'b0;
            if (cnt == 2) keys_n = 16'hFFFF;
            @(negedge clk);
        end
        chk("div_busy_cycles", 32'(cnt), 32'd7);
        chk("div_res", 32'(resultado), 32'd14);
        chk("div_valid", 32'(valid), 32'd1);
        chk("div_erro", 32'(erro), 32'd0);
        chk("div_sinal", 32'(sinal), 32'd0);
        @(negedge clk);
        chk("div_busy_key_ignored", 32'(dut.state_q), 32'(ST_DONE));

        // Divide by zero: op2 7 -> 70 -> 0
        press(15); press(0); press(0);
        chk("op2_zero", 32'(dut.op2_q), 32'd0);
        press(13);
        chk("dz_erro", 32'(erro), 32'd1);
        chk("dz_res", 32'(resultado), 32'd0);
        chk("dz_valid", 32'(valid), 32'd1);
        chk("dz_busy", 32'(busy), 32'd0);
        press(10);
        chk("erro_clear", 32'(erro), 32'd0);
        @(negedge clk);
        chk("add_after_dz", 32'(resultado), 32'd99);

        // Reset in DIV cycle 3
        press(15); press(7);
        press(13);            // now in DIV cycle 1
        @(negedge clk);       // cycle 2
        @(negedge clk);       // cycle 3
        chk("div_c3_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("rst_div");
        chk("rst_div_op2", 32'(dut.op2_q), 32'd0);
        rst = 1'b0;
`else
        // Reset from DONE with a held result
        press(15); press(8); press(10); @(negedge clk);
        chk("add_8", 32'(resultado), 32'd11);
        chk("erro_tied", 32'(erro), 32'd0);
        press(13);
        chk("d_ignored_state", 32'(dut.state_q), 32'(ST_DONE));
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("rst_done");
        chk("rst_done_op2", 32'(dut.op2_q), 32'd0);
        rst = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_calc.md
KEYPAD_CALC -- requirements
Module: keypad_calc

Interface
REQ-001 Parameter DIGITS, default 2, decimal digits per operand (1..4); operand max 10^DIGITS-1.
REQ-002 Derived constant W = clog2(10^DIGITS), operand width; result width 2W.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 keys_n  input  16  active-low keypad; bits 0-9 digits, 10=A add, 11=B sub, 12=C mul, 13=D div, 14=* select operand 1, 15=# select operand 2.
REQ-006 resultado  output  2W  magnitude of last result.
REQ-007 sinal  output  1  1 = result negative.
REQ-008 valid  output  1  resultado/sinal hold a fresh result.
REQ-009 busy  output  1  calculation in progress; keys ignored.
REQ-010 erro  output  1  division by zero flagged.

Function
REQ-011 keys_n shall be registered once, then edge-detected: a key is accepted only in the cycle it goes released->pressed; held keys act once.
REQ-012 Multiple keys newly pressed in the same cycle: lowest index accepted, the rest discarded until re-pressed.
REQ-013 FSM states: ENTRY1, ENTRY2, CALC, DIV, DONE; encoding from the package.
REQ-014 In ENTRY1/ENTRY2 a digit d shall update the selected operand to (op mod 10^(DIGITS-1))*10 + d, discarding the most significant digit.
REQ-015 * from ENTRY2 or DONE -> ENTRY1; # from ENTRY1 or DONE -> ENTRY2; operands retained; valid cleared.
REQ-016 A/B/C in ENTRY1, ENTRY2 or DONE -> CALC; result registered in CALC; next cycle DONE with valid=1 (valid 1 cycle after key accept).
REQ-017 Add: resultado=op1+op2, sinal=0; mul: resultado=op1*op2, sinal=0.
REQ-018 Sub: op1>=op2 gives op1-op2, sinal=0; else op2-op1, sinal=1.
REQ-019 Digit keys in DONE shall be ignored; valid stays 1 until * or # or a new operator key is accepted.
REQ-020 busy=1 in CALC and DIV; all keys accepted while busy are discarded.
REQ-021 Zero-valued operands are legal; no output saturation occurs since 2W bits cover (10^DIGITS-1)^2.

Reset
REQ-022 rst shall force ENTRY1, op1=op2=0, resultado=0, sinal=0, valid=0, busy=0, erro=0, edge-detect history = all released, in the following cycle, from any state including mid-division.

Configuration
REQ-023 With KEYPAD_CALC_DIV_EN defined: D in ENTRY1/ENTRY2/DONE starts division; op2=0 -> DONE next cycle with erro=1, resultado=0, sinal=0; else restoring divide, W cycles in DIV, quotient in resultado, sinal=0, erro=0, valid in the cycle after the last iteration.
REQ-024 erro shall clear when the next operator key is accepted.
REQ-025 Without KEYPAD_CALC_DIV_EN: D key ignored, no divider logic, DIV state absent, erro tied 0.

Structure
REQ-026 Package keypad_calc_pkg shall hold key-index constants, FSM state typedef, operator typedef.
REQ-027 Divider shall be sub-module keypad_calc_div (start/done handshake, W-cycle restoring), instantiated only under KEYPAD_CALC_DIV_EN.

Verification (DIGITS=2, W=7)
REQ-028 rst; *,1,2,#,3,4,A -> resultado=46, sinal=0, valid=1 exactly 1 cycle after A accepted.
REQ-029 op1=12, op2=34, B -> resultado=22, sinal=1; then *,4,5,B -> op1=45, resultado=11, sinal=0.
REQ-030 *,1,2,3 -> op1=23; #,9,9,C -> resultado=2277, sinal=0.
REQ-031 Digit 5 held 10 cycles in ENTRY1 from op1=0 -> op1=5 (not 55); keys 3 and 7 pressed same cycle -> op1=3.
REQ-032 DIV_EN: 99 / 7 -> busy 7 cycles, resultado=14, valid=1; op2=0, D -> erro=1, resultado=0; keys during busy ignored.
REQ-033 rst asserted in DIV cycle 3 -> all outputs at reset values next cycle, state ENTRY1.
